// File: rtl/adder_operand_sequencer_pkg.sv
// Shared types and constants for the adder operand sequencer.
package adder_operand_sequencer_pkg;

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    ST_GET_A   = 2'd0,
    ST_GET_B   = 2'd1,
    ST_SETTLE  = 2'd2,
    ST_RESULT  = 2'd3
  } seq_state_e;

endpackage

// File: rtl/adder_operand_sequencer_if.sv
// Operand input stream, adder operand/return wires and result handshake.
interface adder_operand_sequencer_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] sum_in;
  logic             cout_in;
  logic [WIDTH-1:0] res_sum;
  logic             res_cout;
  logic             res_valid;
  logic             res_ready;

  modport slave (
    input  in_data, in_valid, sum_in, cout_in, res_ready,
    output in_ready, op_a, op_b, res_sum, res_cout, res_valid
  );

  modport master (
    output in_data, in_valid, sum_in, cout_in, res_ready,
    input  in_ready, op_a, op_b, res_sum, res_cout, res_valid
  );
endinterface

// File: rtl/adder_operand_sequencer_settle_timer.sv
// Loadable down-counter; done_c flags that the settle window has elapsed.
module adder_operand_sequencer_settle_timer
  import adder_operand_sequencer_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             load,
  input  logic [CNT_W-1:0] value,
  output logic             done_c
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Load wins over counting; counter parks at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = value;
    end else if (ena && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_c = (cnt_q == '0);

endmodule

// File: rtl/adder_operand_sequencer.sv
// Serialises two operand bytes into the external adder and captures its result
// after a fixed settle window, offering it on a valid/ready port.
module adder_operand_sequencer
  import adder_operand_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        ena,
  adder_operand_sequencer_if.slave    bus,
  output logic                        busy
);

  seq_state_e       state_q, state_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic [WIDTH-1:0] res_sum_q, res_sum_d;
  logic             res_cout_q, res_cout_d;
  logic             res_valid_q, res_valid_d;
  logic             busy_q, busy_d;
  logic             load_c;
  logic             done_c;
  logic             in_ready_c;

  adder_operand_sequencer_settle_timer u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena && (state_q == ST_SETTLE)),
    .load   (load_c),
    .value  (CNT_W'(SETTLE_CYCLES - 1)),
    .done_c (done_c)
  );

  // Ready is a pure decode of registered state, gated off while frozen.
  assign in_ready_c = ena && ((state_q == ST_GET_A) || (state_q == ST_GET_B));

  always_comb begin
    state_d     = state_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    res_sum_d   = res_sum_q;
    res_cout_d  = res_cout_q;
    res_valid_d = res_valid_q;
    load_c      = 1'b0;
    if (ena) begin
      unique case (state_q)
        ST_GET_A: begin
          if (bus.in_valid) begin
            op_a_d  = bus.in_data;
            state_d = ST_GET_B;
          end
        end
        ST_GET_B: begin
          if (bus.in_valid) begin
            op_b_d  = bus.in_data;
            load_c  = 1'b1;
            state_d = ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (done_c) begin
            res_sum_d   = bus.sum_in;
            res_cout_d  = bus.cout_in;
            res_valid_d = 1'b1;
            state_d     = ST_RESULT;
          end
        end
        ST_RESULT: begin
          if (bus.res_ready) begin
            res_valid_d = 1'b0;
            state_d     = ST_GET_A;
          end
        end
        default: state_d = ST_GET_A;
      endcase
    end
    busy_d = (state_d != ST_GET_A);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_GET_A;
      op_a_q      <= '0;
      op_b_q      <= '0;
      res_sum_q   <= '0;
      res_cout_q  <= 1'b0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      res_sum_q   <= res_sum_d;
      res_cout_q  <= res_cout_d;
      res_valid_q <= res_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.op_a      = op_a_q;
  assign bus.op_b      = op_b_q;
  assign bus.res_sum   = res_sum_q;
  assign bus.res_cout  = res_cout_q;
  assign bus.res_valid = res_valid_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_adder_operand_sequencer.sv
// Directed bench for adder_operand_sequencer; the bench plays the external adder.
module tb_adder_operand_sequencer;

  localparam int unsigned W = 8;
  localparam int unsigned S = 2;

  logic clk;
  logic rst_n;
  logic ena;
  logic busy;
  int   checks;
  int   errors;

  adder_operand_sequencer_if #(.WIDTH(W)) bus ();

  adder_operand_sequencer #(.WIDTH(W), .SETTLE_CYCLES(S)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .bus   (bus.slave),
    .busy  (busy)
  );

  assign {bus.cout_in, bus.sum_in} = 9'(bus.op_a) + 9'(bus.op_b);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic send_byte(input logic [7:0] d);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.res_valid !== 1'b0 || busy !== 1'b0 || bus.op_a !== 8'h00 || bus.op_b !== 8'h00 ||
        bus.res_sum !== 8'h00 || bus.res_cout !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: rv=%b busy=%b a=%h b=%h sum=%h cout=%b, want all 0",
               bus.res_valid, busy, bus.op_a, bus.op_b, bus.res_sum, bus.res_cout);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: in_ready=%b busy=%b, want 1 0", bus.in_ready, busy);
    end
  endtask

  task automatic test_basic();
    bus.res_ready = 1'b1;
    send_byte(8'h12);
    checks++;
    if (bus.op_a !== 8'h12 || busy !== 1'b1 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL basic_get_a: op_a=%h busy=%b in_ready=%b, want 12 1 1", bus.op_a, busy, bus.in_ready);
    end
    send_byte(8'h34);
    checks++;
    if (bus.op_b !== 8'h34 || bus.in_ready !== 1'b0 || bus.res_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_get_b: op_b=%h in_ready=%b rv=%b, want 34 0 0", bus.op_b, bus.in_ready, bus.res_valid);
    end
    for (int i = 1; i < S; i++) begin
      @(negedge clk);
      checks++;
      if (bus.res_valid !== 1'b0) begin
        errors++;
        $display("FAIL basic_early_valid: cycle %0d rv=%b, want 0", i, bus.res_valid);
      end
    end
    @(negedge clk);
    checks++;
    if (bus.res_valid !== 1'b1 || bus.res_sum !== 8'h46 || bus.res_cout !== 1'b0) begin
      errors++;
      $display("FAIL basic_result: rv=%b sum=%h cout=%b, want 1 46 0", bus.res_valid, bus.res_sum, bus.res_cout);
    end
    @(negedge clk);
    checks++;
    if (bus.res_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_retire: rv=%b busy=%b, want 0 0", bus.res_valid, busy);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] a [2];
    logic [7:0] b [2];
    logic [8:0] e [2];
    a[0] = 8'hFF; b[0] = 8'h01; e[0] = 9'h100;
    a[1] = 8'h80; b[1] = 8'h80; e[1] = 9'h100;
    bus.res_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      send_byte(a[i]);
      send_byte(b[i]);
      repeat (S) @(negedge clk);
      checks++;
      if (bus.res_valid !== 1'b1 || {bus.res_cout, bus.res_sum} !== e[i]) begin
        errors++;
        $display("FAIL wrap_%0d: rv=%b cout_sum=%h, want 1 %h", i, bus.res_valid, {bus.res_cout, bus.res_sum}, e[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_hold();
    bus.res_ready = 1'b0;
    send_byte(8'h3C);
    send_byte(8'hC5);
    repeat (S) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = i[0];
      bus.in_data  = 8'(i * 17);
      #1;
      checks++;
      if (bus.in_ready !== 1'b0 || bus.res_valid !== 1'b1 || bus.res_sum !== 8'h01 ||
          bus.res_cout !== 1'b1 || bus.op_a !== 8'h3C || bus.op_b !== 8'hC5) begin
        errors++;
        $display("FAIL hold_%0d: rdy=%b rv=%b sum=%h cout=%b a=%h b=%h, want 0 1 01 1 3c c5",
                 i, bus.in_ready, bus.res_valid, bus.res_sum, bus.res_cout, bus.op_a, bus.op_b);
      end
      @(negedge clk);
    end
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'h77;
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.in_valid  = 1'b0;
    checks++;
    if (bus.res_valid !== 1'b0 || busy !== 1'b0 || bus.op_a !== 8'h3C) begin
      errors++;
      $display("FAIL hold_retire: rv=%b busy=%b op_a=%h, want 0 0 3c", bus.res_valid, busy, bus.op_a);
    end
  endtask

  task automatic test_reset_mid();
    bus.res_ready = 1'b0;
    send_byte(8'h55);
    send_byte(8'hAA);
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.op_a !== 8'h00 || bus.op_b !== 8'h00 || bus.res_sum !== 8'h00 || bus.res_cout !== 1'b0 ||
        bus.res_valid !== 1'b0 || busy !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid: a=%h b=%h sum=%h cout=%b rv=%b busy=%b rdy=%b, want 0 0 0 0 0 0 1",
               bus.op_a, bus.op_b, bus.res_sum, bus.res_cout, bus.res_valid, busy, bus.in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (S + 2) @(negedge clk);
    checks++;
    if (bus.res_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_after: rv=%b busy=%b, want 0 0", bus.res_valid, busy);
    end
  endtask

  task automatic test_ena();
    bus.res_ready = 1'b1;
    send_byte(8'h21);
    ena          = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h99;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (bus.in_ready !== 1'b0 || bus.op_b !== 8'h00 || bus.op_a !== 8'h21 || busy !== 1'b1) begin
        errors++;
        $display("FAIL ena_freeze_%0d: rdy=%b a=%h b=%h busy=%b, want 0 21 00 1",
                 i, bus.in_ready, bus.op_a, bus.op_b, busy);
      end
      @(negedge clk);
    end
    ena         = 1'b1;
    bus.in_data = 8'h43;
    @(negedge clk);
    bus.in_valid = 1'b0;
    checks++;
    if (bus.op_b !== 8'h43 || bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL ena_resume: op_b=%h rdy=%b, want 43 0", bus.op_b, bus.in_ready);
    end
    repeat (S - 1) @(negedge clk);
    ena = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (bus.res_valid !== 1'b0) begin
      errors++;
      $display("FAIL ena_settle_frozen: rv=%b, want 0", bus.res_valid);
    end
    ena = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.res_valid !== 1'b1 || bus.res_sum !== 8'h64 || bus.res_cout !== 1'b0) begin
      errors++;
      $display("FAIL ena_result: rv=%b sum=%h cout=%b, want 1 64 0", bus.res_valid, bus.res_sum, bus.res_cout);
    end
    ena = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.res_valid !== 1'b1) begin
      errors++;
      $display("FAIL ena_hold_valid: rv=%b, want 1", bus.res_valid);
    end
    ena = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes [8];
    logic [8:0] e [4];
    int k;
    int r;
    bytes[0] = 8'h01; bytes[1] = 8'h02; e[0] = 9'h003;
    bytes[2] = 8'h7F; bytes[3] = 8'h01; e[1] = 9'h080;
    bytes[4] = 8'hFE; bytes[5] = 8'h03; e[2] = 9'h101;
    bytes[6] = 8'hAA; bytes[7] = 8'h55; e[3] = 9'h0FF;
    k = 0;
    r = 0;
    bus.res_ready = 1'b1;
    for (int cyc = 0; cyc < 100 && r < 4; cyc++) begin
      if (bus.res_valid === 1'b1) begin
        checks++;
        if ({bus.res_cout, bus.res_sum} !== e[r]) begin
          errors++;
          $display("FAIL b2b_result_%0d: cout_sum=%h, want %h", r, {bus.res_cout, bus.res_sum}, e[r]);
        end
        r++;
      end
      if (k < 8) begin
        bus.in_valid = 1'b1;
        bus.in_data  = bytes[k];
        #1;
        if (bus.in_ready === 1'b1) k++;
      end else begin
        bus.in_valid = 1'b0;
      end
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    checks++;
    if (r !== 4 || k !== 8) begin
      errors++;
      $display("FAIL b2b_count: results=%0d bytes=%0d, want 4 8", r, k);
    end
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rst_n         = 1'b0;
    ena           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.res_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_wrap();
    test_hold();
    test_reset_mid();
    test_ena();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
